// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 decryptor.
package aes_dec_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_KEXP,
        S_ROUND,
        S_DONE
    } state_t;

    // AES-128 round count
    localparam logic [3:0] NR = 4'd10;

    // Round constant table, index 0 holds Rcon for round 1
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] v;
        case (idx)
            4'd0:    v = 8'h01;
            4'd1:    v = 8'h02;
            4'd2:    v = 8'h04;
            4'd3:    v = 8'h08;
            4'd4:    v = 8'h10;
            4'd5:    v = 8'h20;
            4'd6:    v = 8'h40;
            4'd7:    v = 8'h80;
            4'd8:    v = 8'h1b;
            4'd9:    v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // InvMixColumns on one column, row 0 byte in bits [31:24]
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, pure combinational lookup.
module aes_inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Entry 0 sits in the top byte, so index from the MSB end
    always_comb begin
        o_byte = INV_SBOX[{~i_byte, 3'b000} +: 8];
    end

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, pure combinational lookup.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so index from the MSB end
    always_comb begin
        o_byte = SBOX[{~i_byte, 3'b000} +: 8];
    end

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryptor: forward key expansion to rk10, then ten
// inverse rounds that walk the round key backwards one step per edge.
// Optional key cache (skips expansion on repeated key): AES_DEC_KEYCACHE_EN.
module aes_dec_iter
    import aes_dec_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt,
    output logic         busy
);

    state_t       r_fsm;
    logic [3:0]   r_cnt;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [127:0] r_pt;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;
`ifdef AES_DEC_KEYCACHE_EN
    logic [127:0] r_cache_key;
    logic [127:0] r_cache_rk10;
    logic         r_cache_vld;
`endif

    logic         w_last;
    logic [31:0]  w_sub_in;
    logic [31:0]  w_rot;
    logic [31:0]  w_subw;
    logic [127:0] w_rk_next;
    logic [127:0] w_rk_prev;
    logic [127:0] w_rin;
    logic [127:0] w_isr;
    logic [127:0] w_isb;
    logic [127:0] w_ark;
    logic [127:0] w_imc;
    logic [127:0] w_round;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign pt        = r_pt;
    assign busy      = r_busy;

    // Final step of both the expansion phase and the round phase
    always_comb begin
        w_last = (r_cnt == NR - 4'd1);
    end

    // Shared SubWord input: w3 for forward expansion, w3^w2 (previous w3) for the inverse step
    always_comb begin
        w_sub_in = (r_fsm == S_KEXP) ? r_key[31:0] : (r_key[31:0] ^ r_key[63:32]);
        w_rot    = {w_sub_in[23:0], w_sub_in[31:24]};
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_ks_sbox
            aes_sbox u_sbox (
                .i_byte (w_rot[8*g +: 8]),
                .o_byte (w_subw[8*g +: 8])
            );
        end
    endgenerate

    // Forward step rk(n) -> rk(n+1) and inverse step rk(n) -> rk(n-1)
    always_comb begin
        logic [31:0] t_fwd;
        logic [31:0] n0, n1, n2, n3;
        t_fwd = w_subw ^ {rcon(r_cnt), 24'h0};
        n0 = r_key[127:96] ^ t_fwd;
        n1 = r_key[95:64]  ^ n0;
        n2 = r_key[63:32]  ^ n1;
        n3 = r_key[31:0]   ^ n2;
        w_rk_next = {n0, n1, n2, n3};
        // r_key holds rk(10-r_cnt) during rounds, so its Rcon index is 9-r_cnt
        w_rk_prev = {r_key[127:96] ^ w_subw ^ {rcon(4'd9 - r_cnt), 24'h0},
                     r_key[95:64] ^ r_key[127:96],
                     r_key[63:32] ^ r_key[95:64],
                     r_key[31:0]  ^ r_key[63:32]};
    end

    // Round input with the initial AddRoundKey(rk10) folded into the first round
    always_comb begin
        w_rin = (r_cnt == 4'd0) ? (r_state ^ r_key) : r_state;
    end

    // InvShiftRows: row r rotates right by r columns
    always_comb begin
        w_isr = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                w_isr[8*(15-(4*c+r)) +: 8] = w_rin[8*(15-(4*((c+4-r)%4)+r)) +: 8];
            end
        end
    end

    generate
        for (g = 0; g < 16; g++) begin : g_inv_sbox
            aes_inv_sbox u_inv_sbox (
                .i_byte (w_isr[8*g +: 8]),
                .o_byte (w_isb[8*g +: 8])
            );
        end
    endgenerate

    // AddRoundKey with the previous round key, then InvMixColumns except on the last round
    always_comb begin
        w_ark = w_isb ^ w_rk_prev;
        w_imc = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            w_imc[32*(3-c) +: 32] = inv_mix_col(w_ark[32*(3-c) +: 32]);
        end
        w_round = w_last ? w_ark : w_imc;
    end

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm       <= S_IDLE;
            r_cnt       <= '0;
            r_state     <= '0;
            r_key       <= '0;
            r_pt        <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef AES_DEC_KEYCACHE_EN
            r_cache_key  <= '0;
            r_cache_rk10 <= '0;
            r_cache_vld  <= 1'b0;
`endif
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state    <= ct;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef AES_DEC_KEYCACHE_EN
                        if (r_cache_vld && (key == r_cache_key)) begin
                            r_key <= r_cache_rk10;
                            r_fsm <= S_ROUND;
                        end else begin
                            r_key       <= key;
                            r_fsm       <= S_KEXP;
                            r_cache_key <= key;
                            r_cache_vld <= 1'b0;
                        end
`else
                        r_key <= key;
                        r_fsm <= S_KEXP;
`endif
                    end
                end
                S_KEXP: begin
                    r_key <= w_rk_next;
                    if (w_last) begin
                        r_cnt <= '0;
                        r_fsm <= S_ROUND;
`ifdef AES_DEC_KEYCACHE_EN
                        r_cache_rk10 <= w_rk_next;
                        r_cache_vld  <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_ROUND: begin
                    r_key   <= w_rk_prev;
                    r_state <= w_round;
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_pt        <= w_round;
                        r_out_valid <= 1'b1;
                        r_fsm       <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_iter.sv
// Directed-vector bench for aes_dec_iter.
module tb_aes_dec_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] ct = '0;
    logic [127:0] key = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] pt;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] CT_K1 = 128'h0545aad56da2a97c3663d1432a3d1c84;
    localparam logic [127:0] KEY_1 = 128'h1;
`ifdef AES_DEC_KEYCACHE_EN
    localparam int HIT_LAT = 10;
`else
    localparam int HIT_LAT = 20;
`endif

    aes_dec_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Present a job on the first cycle in_ready is high; scramble inputs after acceptance
    task automatic run_job(input logic [127:0] c, input logic [127:0] k, output int lat);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        in_valid = 1'b1;
        ct = c;
        key = k;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ct = ~c;
        key = ~k;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Output handshake: one cycle of out_ready
    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (pt !== 128'h0) begin n_err++; $display("FAIL reset_pt: got %h want 0", pt); end
        rst = 1'b1;
    endtask

    task automatic test_fips_vector();
        int lat;
        run_job(CT_A, KEY_A, lat);
        n_vec++; if (lat !== 20) begin n_err++; $display("FAIL fips_latency: got %0d want 20", lat); end
        n_vec++; if (pt !== PT_A) begin n_err++; $display("FAIL fips_pt: got %h want %h", pt, PT_A); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL fips_busy_done: got %b want 1", busy); end
        release_out();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fips_ov_clear: got %b want 0", out_valid); end
        n_vec++; if (pt !== PT_A) begin n_err++; $display("FAIL fips_pt_hold: got %h want %h", pt, PT_A); end
    endtask

    task automatic test_appendix_vector();
        int lat;
        run_job(CT_B, KEY_B, lat);
        n_vec++; if (lat !== 20) begin n_err++; $display("FAIL appx_latency: got %0d want 20", lat); end
        n_vec++; if (pt !== PT_B) begin n_err++; $display("FAIL appx_pt: got %h want %h", pt, PT_B); end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        run_job(CT_Z, '0, lat);
        n_vec++; if (lat !== 20) begin n_err++; $display("FAIL bp_latency: got %0d want 20", lat); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            ct = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            n_vec++; if (pt !== 128'h0) begin n_err++; $display("FAIL bp_pt_hold: got %h want 0", pt); end
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_ov_hold: got %b want 1", out_valid); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_ov: got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_abort();
        int lat;
        int t;
        logic seen;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        in_valid = 1'b1;
        ct = CT_A;
        key = KEY_A;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_vec++; if (pt !== 128'h0) begin n_err++; $display("FAIL abort_pt: got %h want 0", pt); end
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_output: got %b want 0", seen); end
        run_job(CT_A, KEY_A, lat);
        n_vec++; if (lat !== 20) begin n_err++; $display("FAIL abort_next_latency: got %0d want 20", lat); end
        n_vec++; if (pt !== PT_A) begin n_err++; $display("FAIL abort_next_pt: got %h want %h", pt, PT_A); end
        release_out();
    endtask

    task automatic test_ignore_inputs();
        int lat;
        int t;
        logic ready_seen;
        logic extra;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        in_valid = 1'b1;
        ct = CT_B;
        key = KEY_B;
        @(posedge clk);
        #1;
        lat = 0;
        ready_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            ct = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            lat++;
            if (in_ready) ready_seen = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++; if (lat !== 20) begin n_err++; $display("FAIL ign_latency: got %0d want 20", lat); end
        n_vec++; if (pt !== PT_B) begin n_err++; $display("FAIL ign_pt: got %h want %h", pt, PT_B); end
        n_vec++; if (ready_seen !== 1'b0) begin n_err++; $display("FAIL ign_in_ready_low: got %b want 0", ready_seen); end
        release_out();
        extra = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) extra = 1'b1;
        end
        n_vec++; if (extra !== 1'b0) begin n_err++; $display("FAIL ign_no_second_job: got %b want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_job(CT_A, KEY_A, lat);
        n_vec++; if (lat !== 20) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 20", lat); end
        n_vec++; if (pt !== PT_A) begin n_err++; $display("FAIL b2b_first_pt: got %h want %h", pt, PT_A); end
        release_out();
        run_job(CT_A, KEY_A, lat);
        n_vec++; if (lat !== HIT_LAT) begin n_err++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, HIT_LAT); end
        n_vec++; if (pt !== PT_A) begin n_err++; $display("FAIL b2b_second_pt: got %h want %h", pt, PT_A); end
        release_out();
        run_job(CT_K1, KEY_1, lat);
        n_vec++; if (lat !== 20) begin n_err++; $display("FAIL b2b_newkey_latency: got %0d want 20", lat); end
        n_vec++; if (pt !== 128'h0) begin n_err++; $display("FAIL b2b_newkey_pt: got %h want 0", pt); end
        release_out();
    endtask

    initial begin
        test_reset();
        test_fips_vector();
        test_appendix_vector();
        test_backpressure();
        test_reset_abort();
        test_ignore_inputs();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_dec_iter.md
AES_DEC_ITER -- requirements
Module: aes_dec_iter

Interface
REQ-001 The block SHALL have no parameters; AES-128 only (Nk=4, Nr=10).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset); synchronous deassert handled upstream.
REQ-004 in_valid  input  1  ct/key present this cycle.
REQ-005 in_ready  output  1  block can accept a job.
REQ-006 ct  input  128  ciphertext, byte 0 in bits [127:120] (FIPS-197 order).
REQ-007 key  input  128  cipher key (round key 0), same byte order.
REQ-008 out_valid  output  1  pt valid.
REQ-009 out_ready  input  1  consumer accepts pt.
REQ-010 pt  output  128  plaintext, same byte order.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, KEXP, ROUND, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; job accepted at edge T where in_valid && in_ready; ct and key captured at T, later changes on ct/key ignored.
REQ-014 On acceptance: IDLE->KEXP and the step counter SHALL reset to 0.
REQ-015 KEXP SHALL run forward key expansion, one round key per edge, at edges T+1..T+10, ending with round key 10 held; then ->ROUND.
REQ-016 ROUND r (r=1..10, edge T+10+r) SHALL compute: r=1 prepends AddRoundKey(rk10); every round applies InvShiftRows, InvSubBytes, AddRoundKey(rk10-r); r<10 also applies InvMixColumns; the round key register steps backwards via the inverse key schedule in the same edge.
REQ-017 At edge T+20 pt SHALL be loaded and the FSM SHALL enter DONE with out_valid=1 (latency 20 edges from acceptance).
REQ-018 In DONE pt and out_valid SHALL hold until out_ready=1; on that edge DONE->IDLE, out_valid=0 and pt holds its value.
REQ-019 out_ready while not in DONE SHALL be ignored; in_valid while not in IDLE SHALL be ignored and not queued.
REQ-020 A new job MAY be accepted at the earliest on the edge after the output handshake (1 idle cycle minimum between jobs).
REQ-021 All byte arithmetic SHALL be GF(2^8) mod x^8+x^4+x^3+x+1; no carries, no width growth.

Reset
REQ-022 While rst=0: state=IDLE, in_ready=1, out_valid=0, busy=0, pt=0, counter=0, internal state/key registers=0, key cache invalid.
REQ-023 Reset asserted mid-job SHALL abort the job immediately with no output; first job after release behaves as cold start.

Configuration
REQ-024 Macro AES_DEC_KEYCACHE_EN defined: after each completed KEXP the key and rk10 SHALL be cached; if an accepted key equals the cached key, KEXP SHALL be skipped (IDLE->ROUND, out_valid at T+10).
REQ-025 AES_DEC_KEYCACHE_EN undefined: no cache registers; every job SHALL take 20 edges.
REQ-026 Output values SHALL be identical with and without the macro.

Structure
REQ-027 Package aes_dec_pkg SHALL hold: FSM state typedef, NR=10, Rcon table, GF helper functions (xtime, gmul by 9/11/13/14).
REQ-028 Sub-module aes_inv_sbox (256-entry combinational table) SHALL be instantiated 16x for InvSubBytes; key schedule SHALL reuse the codebase's existing forward S-box module (4x).

Verification
REQ-029 ct=3925841d02dc09fbdc118597196a0b32, key=2b7e151628aed2a6abf7158809cf4f3c -> pt=3243f6a8885a308d313198a2e0370734, out_valid 20 edges after acceptance.
REQ-030 ct=69c4e0d86a7b0430d8cdb78070b4c55a, key=000102030405060708090a0b0c0d0e0f -> pt=00112233445566778899aabbccddeeff.
REQ-031 ct=66e94bd4ef8a2c3b884cfa59ca342b2e, key=0 -> pt=0; out_ready held 0 for 5 cycles -> pt/out_valid stable, in_ready=0, then released -> IDLE next edge.
REQ-032 Reset pulsed at edge T+7 of a job -> out_valid never rises, in_ready=1 during reset; following job REQ-029 completes at 20 edges.
REQ-033 With AES_DEC_KEYCACHE_EN: REQ-029 twice back-to-back -> second pt identical, latency 10; then ct=05 45 aa d5 6d a2 a9 7c 36 63 d1 43 2a 3d 1c 84 (contiguous hex), key=1 -> pt=0, latency 20.
REQ-034 in_valid held high with changing ct during a job -> ignored; only one job per acceptance, pt matches captured inputs.
